pic_init_sequencer: RTL

Clocked command sequencer for the 8259A PIC. It takes the CPU bus strobes (CS, write, Read, A0, dataBuffer) and walks the ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialization sequence. Once the PIC is initialized, it routes each write to OCW1, OCW2 or OCW3. It holds all command registers and drives decoded configuration and read-select signals to the control logic, priority resolver and IMR/IRR/ISR blocks.

---
 rtl/pic_init_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pic_init_sequencer.sv
// 8259A command sequencer: walks ICW1..ICW4 initialisation, then routes writes to OCW1..OCW3.
// Build option: define SEQ_ERR_EN to add the sticky seq_err output flagging ignored writes.
module pic_init_sequencer #(
    parameter logic [7:0] IMR_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       write,
    input  logic       Read,
    input  logic       A0,
    input  logic [7:0] dataBuffer,
    output logic [7:0] icw1,
    output logic [7:0] icw2,
    output logic [7:0] icw3,
    output logic [7:0] icw4,
    output logic [7:0] ocw1,
    output logic [7:0] ocw2,
    output logic [7:0] ocw3,
    output logic       init_done,
    output logic       ocw2_strobe,
    output logic [4:0] vector_base,
    output logic       cfg_sngl,
    output logic       cfg_ic4,
    output logic       cfg_ltim,
    output logic       cfg_aeoi,
    output logic       read_isr_sel,
    output logic       read_status,
`ifdef SEQ_ERR_EN
    output logic       read_imr,
    output logic       seq_err
`else
    output logic       read_imr
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state_r;
    state_t     after_icw2_s;
    state_t     after_icw3_s;
    logic       wr_act_s;
    logic       wr_act_d_r;
    logic       commit_s;
    logic       icw1_hit_s;
    logic [7:0] icw1_r, icw2_r, icw3_r, icw4_r;
    logic [7:0] ocw1_r, ocw2_r, ocw3_r;
    logic       init_done_r;
    logic       ocw2_strobe_r;
    logic       read_isr_sel_r;
    logic       read_status_r;
    logic       read_imr_r;
`ifdef SEQ_ERR_EN
    logic       seq_err_r;
`endif

    // ICW3 is only expected in cascade mode, ICW4 only when IC4 asked for it.
    function automatic state_t next_after_icw2(input logic sngl, input logic ic4);
        state_t nxt;
        if (!sngl) begin
            nxt = WAIT_ICW3;
        end else if (ic4) begin
            nxt = WAIT_ICW4;
        end else begin
            nxt = READY;
        end
        return nxt;
    endfunction

    assign wr_act_s     = ~CS & ~write;
    assign commit_s     = wr_act_s & ~wr_act_d_r;
    assign icw1_hit_s   = ~A0 & dataBuffer[4];
    assign after_icw2_s = next_after_icw2(icw1_r[1], icw1_r[0]);
    assign after_icw3_s = icw1_r[0] ? WAIT_ICW4 : READY;

    // Command sequencer: write-edge commit, init walk, OCW routing and read decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            wr_act_d_r     <= 1'b0;
            icw1_r         <= 8'h00;
            icw2_r         <= 8'h00;
            icw3_r         <= 8'h00;
            icw4_r         <= 8'h00;
            ocw1_r         <= IMR_INIT;
            ocw2_r         <= 8'h00;
            ocw3_r         <= 8'h00;
            init_done_r    <= 1'b0;
            ocw2_strobe_r  <= 1'b0;
            read_isr_sel_r <= 1'b0;
            read_status_r  <= 1'b0;
            read_imr_r     <= 1'b0;
`ifdef SEQ_ERR_EN
            seq_err_r      <= 1'b0;
`endif
        end else begin
            wr_act_d_r    <= wr_act_s;
            ocw2_strobe_r <= 1'b0;
            // A concurrent write strobe suppresses both read decodes.
            read_status_r <= ~CS & ~Read & write & ~A0;
            read_imr_r    <= ~CS & ~Read & write & A0;
            if (commit_s) begin
                if (icw1_hit_s) begin
                    state_r        <= WAIT_ICW2;
                    icw1_r         <= dataBuffer;
                    icw2_r         <= 8'h00;
                    icw3_r         <= 8'h00;
                    icw4_r         <= 8'h00;
                    ocw1_r         <= IMR_INIT;
                    ocw3_r         <= 8'h00;
                    read_isr_sel_r <= 1'b0;
                    init_done_r    <= 1'b0;
`ifdef SEQ_ERR_EN
                    seq_err_r      <= 1'b0;
`endif
                end else begin
                    case (state_r)
                        IDLE: begin
`ifdef SEQ_ERR_EN
                            seq_err_r <= 1'b1;
`endif
                        end
                        WAIT_ICW2: begin
                            if (A0) begin
                                icw2_r      <= dataBuffer;
                                state_r     <= after_icw2_s;
                                init_done_r <= (after_icw2_s == READY);
                            end else begin
`ifdef SEQ_ERR_EN
                                seq_err_r <= 1'b1;
`endif
                            end
                        end
                        WAIT_ICW3: begin
                            if (A0) begin
                                icw3_r      <= dataBuffer;
                                state_r     <= after_icw3_s;
                                init_done_r <= ~icw1_r[0];
                            end else begin
`ifdef SEQ_ERR_EN
                                seq_err_r <= 1'b1;
`endif
                            end
                        end
                        WAIT_ICW4: begin
                            if (A0) begin
                                icw4_r      <= dataBuffer;
                                state_r     <= READY;
                                init_done_r <= 1'b1;
                            end else begin
`ifdef SEQ_ERR_EN
                                seq_err_r <= 1'b1;
`endif
                            end
                        end
                        READY: begin
                            if (A0) begin
                                ocw1_r <= dataBuffer;
                            end else if (!dataBuffer[3]) begin
                                ocw2_r        <= dataBuffer;
                                ocw2_strobe_r <= 1'b1;
                            end else begin
                                ocw3_r <= dataBuffer;
                                // RR selects whether RIS updates the status-read source.
                                if (dataBuffer[1]) begin
                                    read_isr_sel_r <= dataBuffer[0];
                                end else begin
                                    read_isr_sel_r <= read_isr_sel_r;
                                end
                            end
                        end
                        default: begin
                            state_r     <= IDLE;
                            init_done_r <= 1'b0;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign icw1         = icw1_r;
    assign icw2         = icw2_r;
    assign icw3         = icw3_r;
    assign icw4         = icw4_r;
    assign ocw1         = ocw1_r;
    assign ocw2         = ocw2_r;
    assign ocw3         = ocw3_r;
    assign init_done    = init_done_r;
    assign ocw2_strobe  = ocw2_strobe_r;
    assign vector_base  = icw2_r[7:3];
    assign cfg_sngl     = icw1_r[1];
    assign cfg_ic4      = icw1_r[0];
    assign cfg_ltim     = icw1_r[3];
    assign cfg_aeoi     = icw4_r[1];
    assign read_isr_sel = read_isr_sel_r;
    assign read_status  = read_status_r;
    assign read_imr     = read_imr_r;
`ifdef SEQ_ERR_EN
    assign seq_err      = seq_err_r;
`endif

endmodule
